// File: rtl/pc_unit.sv
// pc_unit: architectural PC register with PC+4 / branch / jump next-PC datapath and fetch handshake.
// Latency: an acknowledged PC command updates PC on the next rising edge; PC4 follows PC combinationally.
// Backpressure: an unacknowledged non-hold command is parked in a pending register (STALL) until if_ack.
// Optional feature macro: PC_HISTORY_EN (4-entry ring of source PCs of applied 10/11 commands).
module pc_unit #(
   parameter int               WIDTH    = 64,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       PC_FS,
   input  logic [WIDTH-1:0] PC_in,
   input  logic [25:0]      imm26,
   input  logic [18:0]      imm19,
   input  logic             imm_sel,
   input  logic             link_en,
   input  logic             if_ack,
   input  logic [1:0]       hist_idx,
   output logic             if_req,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] PC4,
   output logic [WIDTH-1:0] link,
   output logic             link_valid,
   output logic             align_fault,
   output logic             stalled,
   output logic [WIDTH-1:0] hist_data
);

   typedef enum logic [1:0] {S_RESET_FETCH, S_RUN, S_STALL} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [1:0]       pend_fs_q, pend_fs_d;
   logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
   logic             pend_link_q, pend_link_d;
   logic             pend_mis_q, pend_mis_d;
   logic [WIDTH-1:0] link_q, link_d;
   logic             link_valid_q, link_valid_d;
   logic             align_q, align_d;
   logic             if_req_q, if_req_d;
   logic             stalled_q, stalled_d;

   logic [WIDTH-1:0] pc_plus4, offset, jump_tgt, in_tgt;
   logic             in_mis;
   logic [1:0]       cmd_fs;
   logic [WIDTH-1:0] cmd_tgt;
   logic             cmd_link, cmd_mis, apply, apply_nonseq;

   // Next-PC candidates from the current PC and incoming command
   always_comb begin
      pc_plus4 = pc_q + WIDTH'(4);
      offset   = imm_sel ? {{(WIDTH-21){imm19[18]}}, imm19, 2'b00}
                         : {{(WIDTH-28){imm26[25]}}, imm26, 2'b00};
      jump_tgt = pc_q + offset;
      in_mis   = (PC_FS == 2'b10) && (PC_in[1:0] != 2'b00);
      case (PC_FS)
         2'b01:   in_tgt = pc_plus4;
         2'b10:   in_tgt = {PC_in[WIDTH-1:2], 2'b00};
         2'b11:   in_tgt = jump_tgt;
         default: in_tgt = pc_q;
      endcase
   end

   // Command source (live inputs in RUN, parked command in STALL) and next-state logic
   always_comb begin
      cmd_fs       = (state_q == S_STALL) ? pend_fs_q   : PC_FS;
      cmd_tgt      = (state_q == S_STALL) ? pend_tgt_q  : in_tgt;
      cmd_link     = (state_q == S_STALL) ? pend_link_q : link_en;
      cmd_mis      = (state_q == S_STALL) ? pend_mis_q  : in_mis;
      apply        = if_ack && (state_q != S_RESET_FETCH);
      apply_nonseq = apply && cmd_fs[1];

      state_d      = state_q;
      pc_d         = pc_q;
      pend_fs_d    = pend_fs_q;
      pend_tgt_d   = pend_tgt_q;
      pend_link_d  = pend_link_q;
      pend_mis_d   = pend_mis_q;
      link_d       = link_q;
      link_valid_d = 1'b0;
      align_d      = align_q;

      case (state_q)
         S_RESET_FETCH: state_d = S_RUN;
         S_RUN: begin
            if (!if_ack && PC_FS != 2'b00) begin
               pend_fs_d   = PC_FS;
               pend_tgt_d  = in_tgt;
               pend_link_d = link_en;
               pend_mis_d  = in_mis;
               state_d     = S_STALL;
            end
         end
         S_STALL: if (if_ack) state_d = S_RUN;
         default: state_d = S_RESET_FETCH;
      endcase

      if (apply) begin
         pc_d = cmd_tgt;
         if (cmd_fs == 2'b11 && cmd_link) begin
            link_d       = pc_plus4;
            link_valid_d = 1'b1;
         end
         if (cmd_fs == 2'b10 && cmd_mis) align_d = 1'b1;
      end

      if_req_d  = (state_d != S_RESET_FETCH);
      stalled_d = (state_d == S_STALL);
   end

   // FSM, PC and registered status outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_RESET_FETCH;
         pc_q         <= RESET_PC;
         pend_fs_q    <= 2'b00;
         pend_tgt_q   <= '0;
         pend_link_q  <= 1'b0;
         pend_mis_q   <= 1'b0;
         link_q       <= '0;
         link_valid_q <= 1'b0;
         align_q      <= 1'b0;
         if_req_q     <= 1'b0;
         stalled_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pend_fs_q    <= pend_fs_d;
         pend_tgt_q   <= pend_tgt_d;
         pend_link_q  <= pend_link_d;
         pend_mis_q   <= pend_mis_d;
         link_q       <= link_d;
         link_valid_q <= link_valid_d;
         align_q      <= align_d;
         if_req_q     <= if_req_d;
         stalled_q    <= stalled_d;
      end
   end

   assign PC          = pc_q;
   assign PC4         = pc_plus4;
   assign link        = link_q;
   assign link_valid  = link_valid_q;
   assign align_fault = align_q;
   assign if_req      = if_req_q;
   assign stalled     = stalled_q;

`ifdef PC_HISTORY_EN
   logic [WIDTH-1:0] hist_q [4];
   logic [WIDTH-1:0] hist_d [4];
   logic [1:0]       wp_q, wp_d, rd_ptr;

   // Record the source PC of every applied branch/jump, overwriting the oldest entry
   always_comb begin
      hist_d = hist_q;
      wp_d   = wp_q;
      if (apply_nonseq) begin
         hist_d[wp_q] = pc_q;
         wp_d         = wp_q + 2'd1;
      end
      rd_ptr = wp_q - 2'd1 - hist_idx;
   end

   // History storage and write pointer
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) hist_q[i] <= '0;
         wp_q <= 2'd0;
      end else begin
         hist_q <= hist_d;
         wp_q   <= wp_d;
      end
   end

   assign hist_data = hist_q[rd_ptr];
`else
   logic unused_hist;
   assign unused_hist = ^{hist_idx, apply_nonseq};
   assign hist_data   = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: expected values are queued when stimulus is driven and
// popped for comparison after the clock edge that should produce them.
module tb_pc_unit;

   localparam int W = 64;

   logic         clock = 1'b0;
   logic         reset;
   logic [1:0]   PC_FS;
   logic [W-1:0] PC_in;
   logic [25:0]  imm26;
   logic [18:0]  imm19;
   logic         imm_sel, link_en, if_ack;
   logic [1:0]   hist_idx;
   logic         if_req, link_valid, align_fault, stalled;
   logic [W-1:0] PC, PC4, link, hist_data;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q [$];

   pc_unit #(.WIDTH(W), .RESET_PC(64'h100)) dut (
      .clock(clock), .reset(reset), .PC_FS(PC_FS), .PC_in(PC_in),
      .imm26(imm26), .imm19(imm19), .imm_sel(imm_sel), .link_en(link_en),
      .if_ack(if_ack), .hist_idx(hist_idx), .if_req(if_req), .PC(PC), .PC4(PC4),
      .link(link), .link_valid(link_valid), .align_fault(align_fault),
      .stalled(stalled), .hist_data(hist_data)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [W-1:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs);
      logic [W-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: observed=%0h but scoreboard empty", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, e);
         end
      end
   endtask

   task automatic drive(input logic [1:0] fs, input logic [W-1:0] pin, input logic ack);
      PC_FS  = fs;
      PC_in  = pin;
      if_ack = ack;
   endtask

   initial begin
      reset = 1'b1; PC_FS = 2'b00; PC_in = '0; imm26 = '0; imm19 = '0;
      imm_sel = 1'b0; link_en = 1'b0; if_ack = 1'b0; hist_idx = 2'd0;

      // Reset state
      tick();
      push(64'h100); push(0); push(0); push(0); push(0); push(0); push(0);
      chk("rst_pc", PC); chk("rst_if_req", W'(if_req)); chk("rst_link", link);
      chk("rst_link_valid", W'(link_valid)); chk("rst_align", W'(align_fault));
      chk("rst_stalled", W'(stalled)); chk("rst_hist", hist_data);

      // RESET_FETCH ignores PC_FS; if_req rises afterwards
      reset = 1'b0; drive(2'b01, '0, 1'b1);
      tick();
      push(64'h100); push(1);
      chk("rf_pc", PC); chk("rf_if_req", W'(if_req));

      // Three sequential steps
      for (int i = 1; i <= 3; i++) begin
         tick();
         push(64'h100 + W'(4 * i));
         chk("seq_pc", PC);
      end
      push(64'h110); chk("seq_pc4", PC4);

      // BR to 0x200, then BL with imm26 = -2
      drive(2'b10, 64'h200, 1'b1);
      tick();
      push(64'h200); push(0); chk("br_pc", PC); chk("br_align", W'(align_fault));
      drive(2'b11, '0, 1'b1); imm_sel = 1'b0; imm26 = 26'h3FFFFFE; link_en = 1'b1;
      tick();
      push(64'h1F8); push(64'h204); push(1);
      chk("bl_pc", PC); chk("bl_link", link); chk("bl_link_valid", W'(link_valid));
      drive(2'b00, '0, 1'b1); link_en = 1'b0;
      tick();
      push(64'h1F8); push(0); push(64'h204);
      chk("hold_pc", PC); chk("bl_pulse_end", W'(link_valid)); chk("hold_link", link);

      // Stalled jump with imm19 = 4
      drive(2'b10, 64'h200, 1'b1);
      tick();
      drive(2'b11, '0, 1'b0); imm_sel = 1'b1; imm19 = 19'd4;
      for (int i = 0; i < 3; i++) begin
         tick();
         push(1); push(64'h200); push(1);
         chk("stall_flag", W'(stalled)); chk("stall_pc", PC); chk("stall_if_req", W'(if_req));
         drive(2'b01, '0, 1'b0);  // new commands are ignored while stalled
      end
      if_ack = 1'b1;
      tick();
      push(64'h210); push(0); push(0);
      chk("unstall_pc", PC); chk("unstall_flag", W'(stalled)); chk("unstall_lv", W'(link_valid));

      // Reset while a BL is pending discards it
      drive(2'b11, '0, 1'b0); imm_sel = 1'b0; imm26 = 26'd4; link_en = 1'b1;
      tick();
      push(1); chk("pend_stall", W'(stalled));
      reset = 1'b1;
      tick();
      push(64'h100); push(0); push(0); push(0);
      chk("rst2_pc", PC); chk("rst2_stalled", W'(stalled)); chk("rst2_link", link);
      chk("rst2_lv", W'(link_valid));
      reset = 1'b0; drive(2'b00, '0, 1'b1); link_en = 1'b0;
      tick(); tick();
      push(64'h100); push(0); push(0);
      chk("rst2_after_pc", PC); chk("rst2_after_lv", W'(link_valid)); chk("rst2_after_link", link);

      // Misaligned BR sets a sticky fault
      drive(2'b10, 64'h3003, 1'b1);
      tick();
      push(64'h3000); push(1); chk("mis_pc", PC); chk("mis_align", W'(align_fault));
      drive(2'b01, '0, 1'b1);
      tick(); tick();
      push(64'h3008); push(1); chk("mis_seq_pc", PC); chk("mis_sticky", W'(align_fault));

      // Wrap on PC+4 and on a negative jump from zero
      drive(2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
      tick();
      push(64'h0); chk("wrap_pc4_comb", PC4);
      drive(2'b01, '0, 1'b1);
      tick();
      push(64'h0); chk("wrap_pc", PC);
      drive(2'b11, '0, 1'b1); imm_sel = 1'b0; imm26 = 26'h3FFFFFF;
      tick();
      push(64'hFFFF_FFFF_FFFF_FFFC); chk("wrap_jump", PC);

      // Reset clears the fault
      reset = 1'b1; drive(2'b00, '0, 1'b0);
      tick();
      push(0); chk("rst3_align", W'(align_fault));
      reset = 1'b0; if_ack = 1'b1;
      tick();

      // History: branches sourced from 0x10..0x50
      drive(2'b10, 64'h10, 1'b1);
      tick();
      for (int i = 2; i <= 6; i++) begin
         drive(2'b10, W'(16 * i), 1'b1);
         tick();
      end
      push(64'h60); chk("hist_pc", PC);
      drive(2'b00, '0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         hist_idx = 2'(i);
         #1;
`ifdef PC_HISTORY_EN
         push(64'h50 - W'(16 * i));
`else
         push(64'h0);
`endif
         chk("hist_data", hist_data);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter register and next-PC datapath that executes the PC function select (PC_FS) and branch immediates issued by the control units (branch, ALU, memory). Sits between the control-word decode and instruction memory: holds the architectural PC, computes PC+4 and branch targets, captures the BL link value, and fetches through a req/ack handshake so a stalled fetch never loses a PC command.

## Interface
- WIDTH, 64, PC/data width in bits
- RESET_PC, 64'h0, PC value loaded on reset
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- PC_FS  in  2  PC function: 00 hold, 01 PC+4, 10 load PC_in (BR), 11 jump PC+offset
- PC_in  in  WIDTH  register-sourced target for BR
- imm26  in  26  B/BL word offset
- imm19  in  19  CBZ/B.cond word offset
- imm_sel  in  1  0 selects imm26, 1 selects imm19
- link_en  in  1  BL: capture return address when jump is applied
- if_ack  in  1  instruction memory accepted current PC this cycle
- if_req  out  1  fetch request for PC
- PC  out  WIDTH  current program counter
- PC4  out  WIDTH  PC+4 (combinational from PC)
- link  out  WIDTH  last captured return address
- link_valid  out  1  one-cycle pulse when link updates
- align_fault  out  1  sticky: BR target had PC_in[1:0] != 0
- stalled  out  1  high while state is STALL
- hist_idx  in  2  history read index (0 = most recent)
- hist_data  out  WIDTH  history entry (only with PC_HISTORY_EN)

## Operation
- Offset: sext(imm26 or imm19) << 2, extended to WIDTH; target = PC + offset, modulo 2^WIDTH (wraps silently). PC+4 also wraps.
- BR: PC <= {PC_in[WIDTH-1:2], 2'b00}; if PC_in[1:0] != 0, set align_fault.
- FSM states: RESET_FETCH, RUN, STALL.
  - RESET_FETCH: entered on reset; if_req=0 for this one cycle; next RUN. PC_FS ignored.
  - RUN: if_req=1. If if_ack=1, apply PC_FS this cycle, stay RUN. If if_ack=0 and PC_FS!=00: latch command (PC_FS, computed target, link_en) into pending register, go STALL. If if_ack=0 and PC_FS=00: stay RUN.
  - STALL: if_req=1, stalled=1, new PC_FS ignored. On if_ack=1: apply pending command, return RUN.
- Target for pending jump is computed from the PC at latch time (PC unchanged while stalled, so identical).
- Link: on applying 11 with link_en=1, link <= PC+4 of the PC before update; link_valid=1 next cycle only. link_en with any other PC_FS is ignored.
- Reset mid-STALL: pending command discarded, no link update.

## Timing
- Reset values: PC=RESET_PC, if_req=0, link=0, link_valid=0, align_fault=0, stalled=0, hist entries=0, state RESET_FETCH.
- PC update latency: 1 cycle from acknowledged command edge; PC4 valid combinationally same cycle as PC.
- Stalled command: PC updates on the edge where if_ack=1 in STALL.
- align_fault asserts the cycle after the faulting BR is applied; cleared only by reset.

## Configuration
- PC_HISTORY_EN defined: 4-entry ring of source PCs of applied non-sequential commands (10, 11); write pointer advances on each, oldest overwritten; hist_data = entry hist_idx back from newest, registered reads not required (combinational mux). Not defined: no storage, hist_data tied to 0.

## Test plan
- Reset with RESET_PC=0x100 -> PC=0x100, if_req=0 one cycle, then 1; three PC_FS=01 with if_ack=1 -> PC=0x10C.
- PC=0x200, PC_FS=11, imm_sel=0, imm26=26'h3FFFFFE (-2), link_en=1 -> PC=0x1F8, link=0x204, link_valid pulse one cycle.
- PC=0x200, PC_FS=11, imm_sel=1, imm19=4, if_ack=0 for 3 cycles then 1 -> stalled=1 three cycles, PC stays 0x200, then 0x210.
- PC_FS=10, PC_in=0x3003 -> PC=0x3000, align_fault=1 stays high until reset.
- PC=0xFFFF_FFFF_FFFF_FFFC, PC_FS=01 -> PC=0x0 (wrap).
- PC_HISTORY_EN: branches from 0x10,0x20,0x30,0x40,0x50 -> hist_idx 0..3 read 0x50,0x40,0x30,0x20.
